// File: rtl/card_dealer.sv
// card_dealer: deck RAM fill, LFSR-driven Fisher-Yates shuffle and card dealing.
// Build option: define FIXED_DECK_EN to skip the shuffle and deal in fill order.
module card_dealer #(
  parameter int          DECK_SIZE = 52,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       slow_clock,
  input  logic       reset,
  input  logic       shuffle_req,
  input  logic       load_pcard1,
  input  logic       load_pcard2,
  input  logic       load_pcard3,
  input  logic       load_dcard1,
  input  logic       load_dcard2,
  input  logic       load_dcard3,
  output logic [3:0] new_card,
  output logic       card_valid,
  output logic       ready,
  output logic [5:0] cards_left,
  output logic       deck_empty,
  output logic       underflow,
  output logic       multi_req_err
);

  localparam logic [2:0] S_INIT    = 3'd0;
  localparam logic [2:0] S_PICK    = 3'd1;
  localparam logic [2:0] S_SWAP_RD = 3'd2;
  localparam logic [2:0] S_SWAP_WR = 3'd3;
  localparam logic [2:0] S_READY   = 3'd4;

  localparam logic [5:0] DSZ  = 6'(DECK_SIZE);
  localparam logic [5:0] LAST = 6'(DECK_SIZE - 1);

  logic [2:0]  r_state;
  logic [5:0]  r_idx;
  logic [3:0]  r_fill;
  logic [5:0]  r_ptr;
  logic [15:0] r_lfsr;
  logic [5:0]  r_load_q;
  logic [3:0]  r_deck [DECK_SIZE];

  logic [3:0]  r_new_card;
  logic        r_card_valid;
  logic        r_ready;
  logic [5:0]  r_cards_left;
  logic        r_deck_empty;
  logic        r_underflow;
  logic        r_multi;

`ifndef FIXED_DECK_EN
  logic [5:0]  r_i;
  logic [5:0]  r_j;
  logic [3:0]  r_tmp_i;
  logic [3:0]  r_tmp_j;
  logic [5:0]  w_j;
`endif

  logic [5:0]  w_load;
  logic [5:0]  w_rise;
  logic        w_req;
  logic        w_multi;
  logic [15:0] w_lfsr_next;

  assign w_load = {load_dcard3, load_dcard2, load_dcard1,
                   load_pcard3, load_pcard2, load_pcard1};

  // one request per rising edge of the OR of all strobes
  assign w_rise  = w_load & ~r_load_q;
  assign w_req   = (|w_load) & ~(|r_load_q);
  assign w_multi = |(w_rise & (w_rise - 6'd1));

  // Galois LFSR, taps 0xB400
  assign w_lfsr_next = {1'b0, r_lfsr[15:1]}
                     ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);

`ifndef FIXED_DECK_EN
  assign w_j = r_lfsr[5:0];
`endif

  // control FSM, dealing state and status flags
  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_INIT;
      r_idx        <= 6'd0;
      r_fill       <= 4'd1;
      r_ptr        <= 6'd0;
      r_lfsr       <= LFSR_SEED;
      r_load_q     <= 6'd0;
      r_new_card   <= 4'd0;
      r_card_valid <= 1'b0;
      r_ready      <= 1'b0;
      r_cards_left <= DSZ;
      r_deck_empty <= 1'b0;
      r_underflow  <= 1'b0;
      r_multi      <= 1'b0;
`ifndef FIXED_DECK_EN
      r_i          <= 6'd0;
      r_j          <= 6'd0;
`endif
    end else begin
      r_lfsr       <= w_lfsr_next;
      r_load_q     <= w_load;
      r_card_valid <= 1'b0;
      case (r_state)
        S_INIT: begin
          r_fill <= (r_fill == 4'd13) ? 4'd1 : r_fill + 4'd1;
          if (r_idx == LAST) begin
`ifdef FIXED_DECK_EN
            r_state <= S_READY;
            r_ready <= 1'b1;
`else
            r_i     <= LAST;
            r_state <= S_PICK;
`endif
          end else begin
            r_idx <= r_idx + 6'd1;
          end
        end
`ifndef FIXED_DECK_EN
        S_PICK: begin
          if (w_j <= r_i) begin
            r_j     <= w_j;
            r_state <= S_SWAP_RD;
          end
        end
        S_SWAP_RD: begin
          r_state <= S_SWAP_WR;
        end
        S_SWAP_WR: begin
          if (r_i == 6'd1) begin
            r_state <= S_READY;
            r_ready <= 1'b1;
          end else begin
            r_i     <= r_i - 6'd1;
            r_state <= S_PICK;
          end
        end
`endif
        S_READY: begin
          if (shuffle_req) begin
            r_state      <= S_INIT;
            r_idx        <= 6'd0;
            r_fill       <= 4'd1;
            r_ptr        <= 6'd0;
            r_cards_left <= DSZ;
            r_ready      <= 1'b0;
            r_deck_empty <= 1'b0;
            r_underflow  <= 1'b0;
            r_multi      <= 1'b0;
            r_new_card   <= 4'd0;
          end else if (w_req) begin
            if (w_multi) r_multi <= 1'b1;
            if (r_deck_empty) begin
              r_underflow <= 1'b1;
            end else begin
              r_new_card   <= r_deck[r_ptr];
              r_card_valid <= 1'b1;
              r_ptr        <= r_ptr + 6'd1;
              r_cards_left <= r_cards_left - 6'd1;
              r_deck_empty <= (r_cards_left == 6'd1);
            end
          end
        end
        default: begin
          r_state <= S_INIT;
          r_idx   <= 6'd0;
          r_fill  <= 4'd1;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  // deck RAM: fill during INIT, two-entry swap during SWAP_RD/SWAP_WR
  always_ff @(posedge slow_clock) begin
    case (r_state)
      S_INIT: begin
        r_deck[r_idx] <= r_fill;
      end
`ifndef FIXED_DECK_EN
      S_SWAP_RD: begin
        r_tmp_i <= r_deck[r_i];
        r_tmp_j <= r_deck[r_j];
      end
      S_SWAP_WR: begin
        r_deck[r_i] <= r_tmp_j;
        r_deck[r_j] <= r_tmp_i;
      end
`endif
      default: begin
      end
    endcase
  end

  assign new_card      = r_new_card;
  assign card_valid    = r_card_valid;
  assign ready         = r_ready;
  assign cards_left    = r_cards_left;
  assign deck_empty    = r_deck_empty;
  assign underflow     = r_underflow;
  assign multi_req_err = r_multi;

endmodule

// File: tb/tb_card_dealer.sv
// tb_card_dealer: directed bench with a reference deck model and card scoreboard.
// Follows FIXED_DECK_EN in the same way as the design when it is defined.
module tb_card_dealer;

  localparam int          DS   = 52;
  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk;
  logic       rst;
  logic       shuffle_req;
  logic       lp1, lp2, lp3, ld1, ld2, ld3;
  logic [3:0] new_card;
  logic       card_valid;
  logic       ready;
  logic [5:0] cards_left;
  logic       deck_empty;
  logic       underflow;
  logic       multi_req_err;

  card_dealer #(.DECK_SIZE(DS), .LFSR_SEED(SEED)) dut (
    .slow_clock   (clk),
    .reset        (rst),
    .shuffle_req  (shuffle_req),
    .load_pcard1  (lp1),
    .load_pcard2  (lp2),
    .load_pcard3  (lp3),
    .load_dcard1  (ld1),
    .load_dcard2  (ld2),
    .load_dcard3  (ld3),
    .new_card     (new_card),
    .card_valid   (card_valid),
    .ready        (ready),
    .cards_left   (cards_left),
    .deck_empty   (deck_empty),
    .underflow    (underflow),
    .multi_req_err(multi_req_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0]  m_deck [DS];
  logic [15:0] m_lfsr;
  int          m_first_swap;
  logic [3:0]  sb [$];
  logic [3:0]  got [$];
  logic [3:0]  first_order [$];
  logic [3:0]  last_card;
  int          ptr;
  int          exp_left;

  function automatic logic [15:0] adv(input logic [15:0] l);
    return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  // free-running LFSR reference: reset to seed, one step per clock
  always @(posedge clk or posedge rst)
    if (rst) m_lfsr <= SEED;
    else     m_lfsr <= adv(m_lfsr);

  // reference deck build; returns clock edges until ready rises
  function automatic int build(input logic [15:0] l0);
    logic [15:0] l;
    int c;
    int i;
    int j;
    logic [3:0] t;
    l = l0;
    c = 0;
    m_first_swap = -1;
    for (int k = 0; k < DS; k++) begin
      m_deck[k] = 4'(k % 13 + 1);
      l = adv(l);
      c++;
    end
`ifndef FIXED_DECK_EN
    i = DS - 1;
    while (i >= 1) begin
      j = int'(l[5:0]);
      l = adv(l);
      c++;
      if (j <= i) begin
        if (m_first_swap < 0) m_first_swap = c;
        l = adv(adv(l));
        c += 2;
        t = m_deck[i];
        m_deck[i] = m_deck[j];
        m_deck[j] = t;
        i--;
      end
    end
`endif
    if (m_first_swap < 0) m_first_swap = DS - 2;
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_loads(input logic [5:0] m);
    {ld3, ld2, ld1, lp3, lp2, lp1} = m;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int c, input string tag);
    repeat (c - 1) @(posedge clk);
    #1;
    chk({tag, "_ready_lo"}, 32'(ready), 32'd0);
    tick();
    chk({tag, "_ready_hi"}, 32'(ready), 32'd1);
    chk({tag, "_left"}, 32'(cards_left), 32'(DS));
    chk({tag, "_empty"}, 32'(deck_empty), 32'd0);
    ptr = 0;
    exp_left = DS;
  endtask

  // one request edge; scoreboard predicts a card or an underflow
  task automatic deal(input logic [5:0] m, input string tag);
    logic [3:0] e;
    if (exp_left > 0) begin
      sb.push_back(m_deck[ptr]);
      ptr++;
      exp_left--;
    end
    set_loads(m);
    tick();
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_valid"}, 32'(card_valid), 32'd1);
      chk({tag, "_card"}, 32'(new_card), 32'(e));
      got.push_back(new_card);
      last_card = e;
    end else begin
      chk({tag, "_novalid"}, 32'(card_valid), 32'd0);
      chk({tag, "_hold"}, 32'(new_card), 32'(last_card));
      chk({tag, "_uflow"}, 32'(underflow), 32'd1);
    end
    chk({tag, "_left"}, 32'(cards_left), 32'(exp_left));
    set_loads(6'd0);
    tick();
    chk({tag, "_pulse"}, 32'(card_valid), 32'd0);
  endtask

  task automatic hist(input string tag);
    int cnt [14];
    for (int r = 0; r < 14; r++) cnt[r] = 0;
    foreach (got[k]) cnt[got[k]]++;
    for (int r = 1; r <= 13; r++)
      chk($sformatf("%s_rank%0d", tag, r), 32'(cnt[r]), 32'(DS / 13));
  endtask

  task automatic do_shuffle(input string tag);
    shuffle_req = 1'b1;
    tick();
    shuffle_req = 1'b0;
    chk({tag, "_ready"}, 32'(ready), 32'd0);
    chk({tag, "_card"}, 32'(new_card), 32'd0);
    chk({tag, "_left"}, 32'(cards_left), 32'(DS));
    chk({tag, "_uflow"}, 32'(underflow), 32'd0);
    chk({tag, "_multi"}, 32'(multi_req_err), 32'd0);
    chk({tag, "_empty"}, 32'(deck_empty), 32'd0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_card"}, 32'(new_card), 32'd0);
    chk({tag, "_valid"}, 32'(card_valid), 32'd0);
    chk({tag, "_ready"}, 32'(ready), 32'd0);
    chk({tag, "_left"}, 32'(cards_left), 32'(DS));
    chk({tag, "_empty"}, 32'(deck_empty), 32'd0);
    chk({tag, "_uflow"}, 32'(underflow), 32'd0);
    chk({tag, "_multi"}, 32'(multi_req_err), 32'd0);
  endtask

  initial begin
    int c;
    int diff;
    logic [15:0] l0;
    rst = 1'b0;
    shuffle_req = 1'b0;
    set_loads(6'd0);
    last_card = 4'd0;
    ptr = 0;
    exp_left = DS;

    #2 rst = 1'b1;
    #1 chk_reset("rst0");
    @(posedge clk);
    #3 rst = 1'b0;
    c = build(SEED);
    wait_ready(c, "build1");
    chk("build1_uflow0", 32'(underflow), 32'd0);

    got.delete();
    deal(6'b000001, "p1");
    repeat (2) tick();
    deal(6'b001000, "d1");
    repeat (2) tick();
    deal(6'b000010, "p2");
    chk("after3_left", 32'(cards_left), 32'(DS - 3));

    sb.push_back(m_deck[ptr]);
    ptr++;
    exp_left--;
    set_loads(6'b010000);
    tick();
    chk("hold_valid", 32'(card_valid), 32'd1);
    chk("hold_card", 32'(new_card), 32'(sb.pop_front()));
    got.push_back(new_card);
    last_card = new_card;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("hold_quiet%0d", k), 32'(card_valid), 32'd0);
    end
    set_loads(6'd0);
    tick();
    chk("hold_left", 32'(cards_left), 32'(DS - 4));

    for (int k = 4; k < DS; k++)
      deal(6'(1 << (k % 6)), $sformatf("b1_%0d", k));
    chk("b1_empty", 32'(deck_empty), 32'd1);
    chk("b1_zero", 32'(cards_left), 32'd0);
    chk("b1_uflow_pre", 32'(underflow), 32'd0);
    hist("b1");
    first_order = got;
    deal(6'b000100, "b1_extra");
    chk("b1_multi0", 32'(multi_req_err), 32'd0);

    do_shuffle("shuf1");
    l0 = m_lfsr;
    c = build(l0);
    wait_ready(c, "build2");

    got.delete();
    deal(6'b100100, "multi");
    chk("multi_flag", 32'(multi_req_err), 32'd1);
    for (int k = 1; k < DS; k++)
      deal(6'(1 << (k % 6)), $sformatf("b2_%0d", k));
    hist("b2");
    diff = 0;
    foreach (got[k]) if (got[k] !== first_order[k]) diff = 1;
`ifdef FIXED_DECK_EN
    chk("b2_same_order", 32'(diff), 32'd0);
`else
    chk("b2_new_order", 32'(diff), 32'd1);
`endif
    deal(6'b100000, "b2_extra");

    do_shuffle("shuf2");
    l0 = m_lfsr;
    c = build(l0);
    repeat (m_first_swap + 1) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_reset("rst_swap");
    @(posedge clk);
    #3 rst = 1'b0;
    c = build(SEED);
    wait_ready(c, "build3");
    got.delete();
    deal(6'b000001, "b3_first");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: observed no finish, required finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/card_dealer.md
Name: card_dealer

Overview:
- Supplies cards to the baccarat hand controller: owns a DECK_SIZE-entry deck RAM, fills it, shuffles it (LFSR-driven Fisher-Yates) and answers each load_pcard*/load_dcard* strobe with the next card.
- Sits between the controller's load strobes and the card registers/score logic; new_card feeds every card register, each of which latches on its own load strobe.

Parameters:
- DECK_SIZE, 52, cards in deck; must be a multiple of 13 and <= 63.
- LFSR_SEED, 16'hACE1, reset value of the shuffle LFSR; must be nonzero.

Ports:
- slow_clock  in  1  clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high reset.
- shuffle_req  in  1  single-cycle pulse; rebuild and reshuffle the deck.
- load_pcard1, load_pcard2, load_pcard3, load_dcard1, load_dcard2, load_dcard3  in  1 each  card requests from the hand controller; level, may be held several cycles.
- new_card  out  4  rank of the last dealt card, 1..13 (1=A, 11=J, 12=Q, 13=K); 0 = none.
- card_valid  out  1  one-cycle pulse when new_card updates.
- ready  out  1  deck built and dealing allowed.
- cards_left  out  6  DECK_SIZE minus cards dealt.
- deck_empty  out  1  cards_left == 0 while ready.
- underflow  out  1  sticky; request seen while deck_empty.
- multi_req_err  out  1  sticky; more than one load_* rose in the same cycle.

Behaviour:
- Reset (async, any state): state=INIT, idx=0, deal pointer=0, LFSR=LFSR_SEED, new_card=0, card_valid=0, ready=0, cards_left=DECK_SIZE, deck_empty=0, underflow=0, multi_req_err=0.
- LFSR: 16-bit Galois, taps 16'hB400; advances every cycle in every state.
- INIT: write deck[idx] = (idx mod 13)+1, one entry per cycle, idx 0..DECK_SIZE-1 (DECK_SIZE cycles). Then i=DECK_SIZE-1 and go to PICK.
- PICK: j = LFSR[5:0]; if j > i, stay in PICK (retry next cycle with the advanced LFSR); else go to SWAP_RD.
- SWAP_RD: read deck[i] and deck[j] into temporaries (1 cycle).
- SWAP_WR: write both entries swapped (1 cycle). If i==1, go to READY; else i=i-1 and go to PICK.
- READY: ready=1.
  - Request = rising edge of OR(load_*), using the previous cycle's OR registered in-block. A strobe held N cycles deals exactly one card.
  - Request cycle N, deck not empty: at cycle N+1, new_card=deck[ptr], card_valid=1 for one cycle, ptr=ptr+1, cards_left decremented.
  - Back-to-back requests every other cycle are serviced; no request is lost.
- Simultaneous rising edges on two or more load_* lines: one card dealt, multi_req_err set.
- Request while deck_empty: no card_valid, new_card holds its value, underflow set.
- shuffle_req:
  - In READY: go to INIT on the next cycle. ptr=0, cards_left=DECK_SIZE, ready=0, underflow and multi_req_err cleared, new_card=0.
  - In INIT/PICK/SWAP: ignored.
- Requests outside READY: ignored, no flag set.
- Outputs are registered. new_card holds its value between deals.
- All widths are unsigned. ptr and idx are 6 bits. cards_left never wraps below 0.

Optional Feature:
- Macro FIXED_DECK_EN.
- Defined: after INIT go straight to READY (no PICK/SWAP). The deck is dealt in fill order 1,2,..13,1,.. for deterministic benches.
- Undefined: full LFSR shuffle as above.

Test Plan:
- FIXED_DECK_EN, reset then idle -> ready rises exactly DECK_SIZE cycles after reset deasserts; cards_left=52.
- FIXED_DECK_EN, pulse load_pcard1, load_dcard1, load_pcard2 spaced 4 cycles -> card_valid pulses with new_card 1, 2, 3; cards_left 49.
- FIXED_DECK_EN, hold load_dcard2 high 5 cycles -> exactly one card_valid; then 52 deals total, deck_empty=1; 53rd request -> underflow=1, new_card stays 13.
- Shuffled build, deal all 52 cards -> each rank 1..13 appears exactly 4 times; second build after shuffle_req (LFSR advanced) gives a different order.
- load_pcard3 and load_dcard3 rise in the same cycle -> one card_valid, multi_req_err=1; shuffle_req in READY clears it.
- Assert reset mid-SWAP -> all outputs return to reset values immediately; rebuild completes and ready rises again.
